// File: rtl/pic_pkg.sv
// Shared codes for the PIC configuration master: word codes, OCW selector
// encodings, bus-cycle FSM states and the ICW sequencing helper.
package pic_pkg;

    localparam logic [2:0] WORD_ICW1 = 3'b000;
    localparam logic [2:0] WORD_ICW2 = 3'b001;
    localparam logic [2:0] WORD_ICW3 = 3'b010;
    localparam logic [2:0] WORD_ICW4 = 3'b011;
    localparam logic [2:0] WORD_OCW1 = 3'b100;
    localparam logic [2:0] WORD_OCW2 = 3'b101;
    localparam logic [2:0] WORD_OCW3 = 3'b110;
    localparam logic [2:0] WORD_READ = 3'b111;

    typedef enum logic [1:0] {
        OCW_SEL_OCW1 = 2'b00,
        OCW_SEL_OCW2 = 2'b01,
        OCW_SEL_OCW3 = 2'b10,
        OCW_SEL_BAD  = 2'b11
    } ocw_sel_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_RECOV  = 3'd4;

    // Returns {valid, code} of the ICW that follows cur; valid=0 ends the sequence.
    function automatic logic [3:0] next_icw(input logic [2:0] cur, input logic is_init,
                                            input logic sngl, input logic ic4);
        logic [3:0] res;
        res = 4'b0000;
        if (is_init) begin
            case (cur)
                WORD_ICW1: res = {1'b1, WORD_ICW2};
                WORD_ICW2: begin
                    if (!sngl)    res = {1'b1, WORD_ICW3};
                    else if (ic4) res = {1'b1, WORD_ICW4};
                    else          res = 4'b0000;
                end
                WORD_ICW3: begin
                    if (ic4) res = {1'b1, WORD_ICW4};
                    else     res = 4'b0000;
                end
                default:   res = 4'b0000;
            endcase
        end else begin
            res = 4'b0000;
        end
        return res;
    endfunction

endpackage

// File: rtl/pic_cfg_master_if.sv
// PIC-side bus pins: active-low CS/RD/WR, address bit and split data bus.
interface pic_cfg_master_if;
    logic       cs;
    logic       rd;
    logic       wr;
    logic       a0;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] d_in;

    modport master (output cs, rd, wr, a0, d_out, d_oe, input d_in);
    modport slave  (input cs, rd, wr, a0, d_out, d_oe, output d_in);
endinterface

// File: rtl/pic_bus_cycle.sv
// One-word SETUP/STROBE/HOLD/RECOV timing engine; a start on the last RECOV
// cycle chains the next word without passing through IDLE.
module pic_bus_cycle
    import pic_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned RECOV_CYC  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_rw,
    output logic o_cs,
    output logic o_rd,
    output logic o_wr,
    output logic o_oe,
    output logic o_strb_last,
    output logic o_last
);

    localparam logic [7:0] L_SETUP  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] L_STROBE = 8'(STROBE_CYC - 1);
    localparam logic [7:0] L_HOLD   = 8'(HOLD_CYC - 1);
    localparam logic [7:0] L_RECOV  = 8'(RECOV_CYC - 1);

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic       r_rw;
    logic       r_cs, r_rd, r_wr, r_oe;
    logic [2:0] w_nstate;
    logic [7:0] w_ncnt;
    logic       w_nrw;
    logic       w_nact;

    // Next state and phase counter.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_nrw    = r_rw;
        case (r_state)
            ST_IDLE: begin
                w_ncnt = 8'd0;
                if (i_start) begin
                    w_nstate = ST_SETUP;
                    w_nrw    = i_rw;
                end else begin
                    w_nstate = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (r_cnt == L_SETUP) begin w_nstate = ST_STROBE; w_ncnt = 8'd0; end
                else                  begin w_ncnt = r_cnt + 8'd1; end
            end
            ST_STROBE: begin
                if (r_cnt == L_STROBE) begin w_nstate = ST_HOLD; w_ncnt = 8'd0; end
                else                   begin w_ncnt = r_cnt + 8'd1; end
            end
            ST_HOLD: begin
                if (r_cnt == L_HOLD) begin w_nstate = ST_RECOV; w_ncnt = 8'd0; end
                else                 begin w_ncnt = r_cnt + 8'd1; end
            end
            ST_RECOV: begin
                if (r_cnt == L_RECOV) begin
                    w_ncnt = 8'd0;
                    if (i_start) begin
                        w_nstate = ST_SETUP;
                        w_nrw    = i_rw;
                    end else begin
                        w_nstate = ST_IDLE;
                    end
                end else begin
                    w_ncnt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_nstate = ST_IDLE;
                w_ncnt   = 8'd0;
            end
        endcase
        w_nact = (w_nstate == ST_SETUP) || (w_nstate == ST_STROBE) || (w_nstate == ST_HOLD);
    end

    // Status flags for the sequencer, decoded from the current phase.
    always_comb begin
        o_strb_last = (r_state == ST_STROBE) && (r_cnt == L_STROBE);
        o_last      = (r_state == ST_RECOV) && (r_cnt == L_RECOV);
    end

    // State register; bus pins are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_rw    <= 1'b0;
            r_cs    <= 1'b1;
            r_rd    <= 1'b1;
            r_wr    <= 1'b1;
            r_oe    <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_rw    <= w_nrw;
            r_cs    <= !w_nact;
            r_rd    <= !((w_nstate == ST_STROBE) && w_nrw);
            r_wr    <= !((w_nstate == ST_STROBE) && !w_nrw);
            r_oe    <= w_nact && !w_nrw;
        end
    end

    assign o_cs = r_cs;
    assign o_rd = r_rd;
    assign o_wr = r_wr;
    assign o_oe = r_oe;

endmodule

// File: rtl/pic_cfg_master.sv
// CPU-side initiator for an 8259A-style PIC: arbitrates init/OCW/read requests,
// sequences ICW1..ICW4 and formats each word for the bus-cycle engine.
module pic_cfg_master
    import pic_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned RECOV_CYC  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_init_req,
    input  logic                    i_ocw_req,
    input  logic                    i_rd_req,
    input  logic                    i_cfg_ltim,
    input  logic                    i_cfg_sngl,
    input  logic                    i_cfg_ic4,
    input  logic [4:0]              i_cfg_vec,
    input  logic [7:0]              i_cfg_icw3,
    input  logic [4:0]              i_cfg_icw4,
    input  logic [1:0]              i_ocw_sel,
    input  logic [7:0]              i_ocw_data,
    input  logic                    i_rd_a0,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic                    o_init_done,
    output logic [2:0]              o_cur_word,
    output logic [7:0]              o_rd_data,
    pic_cfg_master_if.master        bus
);

    logic       r_busy, r_done, r_err, r_init_done, r_is_init;
    logic [2:0] r_cur_word;
    logic [7:0] r_rd_data, r_dout;
    logic       r_a0;
    logic       r_ltim, r_sngl, r_ic4;
    logic [4:0] r_vec, r_icw4;
    logic [7:0] r_icw3;

    logic       w_idle, w_acc_init, w_acc_ocw, w_rej_ocw, w_acc_rd, w_drop;
    logic       w_cont, w_finish, w_start;
    logic [3:0] w_nxt;
    logic       w_last, w_strb_last;
    logic [2:0] w_code;
    logic       w_a0;
    logic [7:0] w_d;

    // Request arbitration (init > ocw > rd) and word chaining.
    always_comb begin
        w_idle     = !r_busy;
        w_acc_init = w_idle && i_init_req;
        w_acc_ocw  = w_idle && !i_init_req && i_ocw_req && r_init_done && (i_ocw_sel != OCW_SEL_BAD);
        w_rej_ocw  = w_idle && !i_init_req && i_ocw_req && (!r_init_done || (i_ocw_sel == OCW_SEL_BAD));
        w_acc_rd   = w_idle && !i_init_req && !i_ocw_req && i_rd_req;
        w_drop     = r_busy && (i_init_req || i_ocw_req || i_rd_req);
        w_nxt      = next_icw(r_cur_word, r_is_init, r_sngl, r_ic4);
        w_cont     = r_busy && w_last && w_nxt[3];
        w_finish   = r_busy && w_last && !w_nxt[3];
        w_start    = w_acc_init || w_acc_ocw || w_acc_rd || w_cont;
    end

    // Word formatting: the first init word uses live cfg inputs, later ones the latched copy.
    always_comb begin
        w_code = r_cur_word;
        w_a0   = r_a0;
        w_d    = r_dout;
        if (w_acc_init) begin
            w_code = WORD_ICW1;
            w_a0   = 1'b0;
            w_d    = {3'b000, 1'b1, i_cfg_ltim, 1'b0, i_cfg_sngl, i_cfg_ic4};
        end else if (w_acc_ocw) begin
            case (i_ocw_sel)
                OCW_SEL_OCW1: begin w_code = WORD_OCW1; w_a0 = 1'b1; w_d = i_ocw_data; end
                OCW_SEL_OCW2: begin w_code = WORD_OCW2; w_a0 = 1'b0; w_d = {i_ocw_data[7:5], 2'b00, i_ocw_data[2:0]}; end
                OCW_SEL_OCW3: begin w_code = WORD_OCW3; w_a0 = 1'b0; w_d = {i_ocw_data[7:5], 2'b01, i_ocw_data[2:0]}; end
                default:      begin w_code = r_cur_word; w_a0 = r_a0; w_d = r_dout; end
            endcase
        end else if (w_acc_rd) begin
            w_code = WORD_READ;
            w_a0   = i_rd_a0;
            w_d    = 8'h00;
        end else if (w_cont) begin
            case (w_nxt[2:0])
                WORD_ICW2: begin w_code = WORD_ICW2; w_a0 = 1'b1; w_d = {r_vec, 3'b000}; end
                WORD_ICW3: begin w_code = WORD_ICW3; w_a0 = 1'b1; w_d = r_icw3; end
                WORD_ICW4: begin w_code = WORD_ICW4; w_a0 = 1'b1; w_d = {3'b000, r_icw4}; end
                default:   begin w_code = r_cur_word; w_a0 = r_a0; w_d = r_dout; end
            endcase
        end else begin
            w_code = r_cur_word;
            w_a0   = r_a0;
            w_d    = r_dout;
        end
    end

    // Sequencer state, status pulses, latched configuration and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_init_done <= 1'b0;
            r_is_init   <= 1'b0;
            r_cur_word  <= 3'b000;
            r_rd_data   <= 8'h00;
            r_dout      <= 8'h00;
            r_a0        <= 1'b0;
            r_ltim      <= 1'b0;
            r_sngl      <= 1'b0;
            r_ic4       <= 1'b0;
            r_vec       <= 5'd0;
            r_icw3      <= 8'h00;
            r_icw4      <= 5'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_drop || w_rej_ocw;
            if (w_start) begin
                r_cur_word <= w_code;
                r_a0       <= w_a0;
                r_dout     <= w_d;
            end
            if (w_acc_init) begin
                r_ltim      <= i_cfg_ltim;
                r_sngl      <= i_cfg_sngl;
                r_ic4       <= i_cfg_ic4;
                r_vec       <= i_cfg_vec;
                r_icw3      <= i_cfg_icw3;
                r_icw4      <= i_cfg_icw4;
                r_init_done <= 1'b0;
                r_is_init   <= 1'b1;
                r_busy      <= 1'b1;
            end else if (w_acc_ocw || w_acc_rd) begin
                r_is_init <= 1'b0;
                r_busy    <= 1'b1;
            end else if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                if (r_is_init) r_init_done <= 1'b1;
            end
            if (r_busy && w_strb_last && (r_cur_word == WORD_READ)) r_rd_data <= bus.d_in;
        end
    end

    pic_bus_cycle #(
        .SETUP_CYC (SETUP_CYC),
        .STROBE_CYC(STROBE_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .RECOV_CYC (RECOV_CYC)
    ) u_cycle (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_rw       (w_acc_rd),
        .o_cs       (bus.cs),
        .o_rd       (bus.rd),
        .o_wr       (bus.wr),
        .o_oe       (bus.d_oe),
        .o_strb_last(w_strb_last),
        .o_last     (w_last)
    );

    assign bus.a0      = r_a0;
    assign bus.d_out   = r_dout;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_init_done = r_init_done;
    assign o_cur_word  = r_cur_word;
    assign o_rd_data   = r_rd_data;

endmodule
